mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Bus-side responder for the control unit's memory controls (mem_read, mem_write).
//  Turns a single-cycle load/store request into a valid/ready transaction on the data bus.
//  Stalls the core until the bus responds, then returns the load data on read_data.
//  Sits between the datapath's ALU result / rt operand and the external data memory.
// PARAMETERS
//  ADDR_WIDTH      32   byte address width (addr, bus_addr)
//  DATA_WIDTH      32   word width (write_data, read_data, bus_wdata, bus_rdata)
//  TIMEOUT_CYCLES  64   max cycles spent in REQ+WAIT_RSP before abort; must be >= 2
// PORTS
//  clk            in   1           single clock; all state changes on rising edge
//  rst_n          in   1           reset, asynchronous, active-low
//  mem_read       in   1           load request from control
//  mem_write      in   1           store request from control
//  addr           in   ADDR_WIDTH  byte address (ALU result)
//  write_data     in   DATA_WIDTH  store data (rt)
//  read_data      out  DATA_WIDTH  load data, valid in the DONE cycle, held until the next load completes
//  stall          out  1           1 = core must hold the current instruction
//  align_err      out  1           misaligned access flag, combinational, IDLE only
//  mem_err        out  1           bus error or timeout on the access completing this cycle
//  bus_req_valid  out  1           request valid
//  bus_req_ready  in   1           memory accepts the request
//  bus_we         out  1           1 = write, 0 = read
//  bus_addr       out  ADDR_WIDTH  request address, word aligned
//  bus_wdata      out  DATA_WIDTH  request write data
//  bus_rsp_valid  in   1           response / ack valid, single-cycle pulse
//  bus_rdata      in   DATA_WIDTH  read response data
//  bus_err        in   1           error qualifier; sampled with bus_rsp_valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state is IDLE; timeout counter is 0.
//   - read_data, bus_addr, bus_wdata = 0; bus_req_valid, bus_we, mem_err = 0.
//   - Outputs clear immediately, including in the middle of an access; the in-flight access is dropped.
//  access = mem_read | mem_write. If both are 1, the access is a write and mem_read is ignored.
//  FSM: IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE.
//  IDLE:
//   - access and addr[1:0]==0: latch the request, then go to REQ.
//     Latched: bus_addr=addr, bus_wdata=write_data, bus_we=mem_write.
//   - access and addr[1:0]!=0: align_err=1, stall=0, no bus transaction, stay in IDLE.
//   - No access: stay in IDLE.
//  REQ:
//   - bus_req_valid=1. bus_addr, bus_wdata and bus_we are stable until accepted.
//   - On bus_req_valid & bus_req_ready: go to WAIT_RSP.
//  WAIT_RSP:
//   - bus_req_valid=0.
//   - On bus_rsp_valid: go to DONE.
//     A read also loads read_data = bus_err ? 0 : bus_rdata.
//     mem_err is set from bus_err.
//   - bus_rsp_valid is sampled only in WAIT_RSP. It is ignored in every other state, including stray responses.
//  Timeout:
//   - The counter increments every cycle in REQ and WAIT_RSP.
//   - When it reaches TIMEOUT_CYCLES-1 with no completing handshake:
//     go to DONE with mem_err=1; a read also loads read_data=0.
//     bus_req_valid drops.
//   - The counter clears when the FSM enters DONE.
//  DONE:
//   - stall=0. The core advances on this edge. mem_err is valid for exactly this cycle.
//   - Next state is always IDLE; mem_err clears.
//  stall = (IDLE & access & aligned) | REQ | WAIT_RSP. stall is combinational from state and the inputs.
//  Latency: ready=1 with a response on the cycle after accept gives 4 cycles IDLE/REQ/WAIT/DONE; stall=1 for 3.
//  Back-to-back accesses: the access in DONE completes, and the following instruction starts in the IDLE cycle after.
// TESTING
//  T1 load: addr=0x100, mem_read=1, ready=1, rsp one cycle after accept, rdata=0xDEADBEEF.
//     -> bus_we=0, bus_addr=0x100; stall high 3 cycles; DONE read_data=0xDEADBEEF, mem_err=0.
//  T2 store with backpressure: addr=0x204, write_data=0x12345678, ready low 3 cycles.
//     -> bus_req_valid held 4 cycles; bus_addr, bus_wdata and bus_we=1 stable throughout; ack gives DONE, mem_err=0.
//  T3 misaligned: mem_read=1, addr=0x102.
//     -> align_err=1, stall=0, bus_req_valid never asserted; read_data unchanged.
//  T4 timeout: mem_read=1, ready=1, no response.
//     -> DONE after 64 REQ+WAIT cycles; mem_err=1, read_data=0; a later rsp_valid pulse is ignored.
//  T5 bus error: load with bus_err=1 and rdata=0xFFFF0000.
//     -> mem_err=1 in DONE, read_data=0.
//  T6 reset mid-op: rst_n=0 while in WAIT_RSP.
//     -> same cycle: bus_req_valid=0, stall=0, read_data=0; after release, a fresh load completes normally.
//  Every scenario runs to completion with $finish, and every mismatch prints a FAILED message.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a single-cycle load/store request into a valid/ready
// bus transaction, stalls the core until the response (or a timeout) arrives.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall,
    output logic                  align_err,
    output logic                  mem_err,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             access_s;
    logic             aligned_s;
    logic             timeout_s;

    // Request decode, timeout detect and the combinational core-facing flags
    always_comb begin
        access_s  = mem_read | mem_write;
        aligned_s = (addr[1:0] == 2'b00);
        timeout_s = (tmo_cnt_r == CNT_LAST);
        stall     = 1'b0;
        align_err = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall     = access_s & aligned_s;
                align_err = access_s & ~aligned_s;
            end
            ST_REQ:      stall = 1'b1;
            ST_WAIT_RSP: stall = 1'b1;
            ST_DONE:     stall = 1'b0;
            default:     stall = 1'b0;
        endcase
    end

    // Access FSM with registered bus request, load data, error flag and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= {CNT_W{1'b0}};
            read_data     <= {DATA_WIDTH{1'b0}};
            bus_addr      <= {ADDR_WIDTH{1'b0}};
            bus_wdata     <= {DATA_WIDTH{1'b0}};
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tmo_cnt_r <= {CNT_W{1'b0}};
                    if (access_s && aligned_s) begin
                        bus_addr      <= addr;
                        bus_wdata     <= write_data;
                        bus_we        <= mem_write;
                        bus_req_valid <= 1'b1;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An abort wins over a same-cycle accept: nothing completes in REQ.
                    if (timeout_s) begin
                        bus_req_valid <= 1'b0;
                        mem_err       <= 1'b1;
                        tmo_cnt_r     <= {CNT_W{1'b0}};
                        if (!bus_we) begin
                            read_data <= {DATA_WIDTH{1'b0}};
                        end else begin
                            read_data <= read_data;
                        end
                        state_r <= ST_DONE;
                    end else if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        tmo_cnt_r     <= tmo_cnt_r + CNT_W'(1);
                        state_r       <= ST_WAIT_RSP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                        state_r   <= ST_REQ;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        mem_err   <= bus_err;
                        tmo_cnt_r <= {CNT_W{1'b0}};
                        if (!bus_we) begin
                            read_data <= bus_err ? {DATA_WIDTH{1'b0}} : bus_rdata;
                        end else begin
                            read_data <= read_data;
                        end
                        state_r <= ST_DONE;
                    end else if (timeout_s) begin
                        mem_err   <= 1'b1;
                        tmo_cnt_r <= {CNT_W{1'b0}};
                        if (!bus_we) begin
                            read_data <= {DATA_WIDTH{1'b0}};
                        end else begin
                            read_data <= read_data;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                        state_r   <= ST_WAIT_RSP;
                    end
                end
                ST_DONE: begin
                    tmo_cnt_r <= {CNT_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
                default: begin
                    bus_req_valid <= 1'b0;
                    tmo_cnt_r     <= {CNT_W{1'b0}};
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scripted bus responder, a scoreboard of
// expected completions, and immediate-assertion checks at each observation point.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, write_data, read_data;
    logic        stall, align_err, mem_err;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_rsp_valid, bus_err;
    logic [31:0] bus_rdata;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [31:0] model_rd = 32'h0;

    mem_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr          (addr),
        .write_data    (write_data),
        .read_data     (read_data),
        .stall         (stall),
        .align_err     (align_err),
        .mem_err       (mem_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one aligned access and play the bus side until the DONE cycle.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int ready_wait, input logic rsp_en,
                             input logic rsp_err, input logic [31:0] rdata,
                             output int stall_cyc, output int valid_cyc, output logic stable_ok);
        exp_t e;
        int   waited;
        logic accepted, acc_pend, rsp_sent, done;
        waited = 0; accepted = 1'b0; rsp_sent = 1'b0; done = 1'b0;
        valid_cyc = 0; stable_ok = 1'b1;
        e.tag = tag;
        if (!wr) model_rd = (!rsp_en || rsp_err) ? 32'h0 : rdata;
        e.rd  = model_rd;
        e.err = !rsp_en || rsp_err;
        sb_q.push_back(e);
        mem_read = ~wr; mem_write = wr; addr = a; write_data = wd;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(negedge clk);
        stall_cyc = (stall === 1'b1) ? 1 : 0;
        tick;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; write_data = 32'h0;
        for (int c = 0; c < 300 && !done; c++) begin
            bus_req_ready = !accepted && (waited >= ready_wait);
            bus_rsp_valid = accepted && !rsp_sent && rsp_en;
            bus_rdata     = rdata;
            bus_err       = rsp_err;
            @(negedge clk);
            acc_pend = 1'b0;
            if (stall !== 1'b1) done = 1'b1;
            else stall_cyc++;
            if (bus_req_valid === 1'b1) begin
                valid_cyc++;
                if (bus_addr !== a || bus_wdata !== wd || bus_we !== wr) stable_ok = 1'b0;
                if (bus_req_ready) acc_pend = 1'b1;
                else waited++;
            end
            if (bus_rsp_valid) rsp_sent = 1'b1;
            if (done) begin
                e = sb_q.pop_front();
                chk({e.tag, "_rdata"}, read_data, e.rd);
                chk({e.tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, e.err});
            end
            tick;
            if (acc_pend) accepted = 1'b1;
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_err = 1'b0;
        chk({tag, "_reached_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sc, vc;
        logic st, al_ok, st_ok, vl_ok;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; write_data = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_valid_we_err", {29'd0, bus_req_valid, bus_we, mem_err}, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // T1 load, zero wait states
        do_access("t1", 1'b0, 32'h100, 32'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF, sc, vc, st);
        chk("t1_stall_cycles", sc, 32'd3);
        chk("t1_valid_cycles", vc, 32'd1);
        chk("t1_req_fields", {31'd0, st}, 32'd1);

        // T2 store with 3 cycles of backpressure
        do_access("t2", 1'b1, 32'h204, 32'h12345678, 3, 1'b1, 1'b0, 32'h55555555, sc, vc, st);
        chk("t2_valid_cycles", vc, 32'd4);
        chk("t2_req_stable", {31'd0, st}, 32'd1);

        // T3 misaligned load: flagged, never reaches the bus
        mem_read = 1'b1; addr = 32'h102;
        al_ok = 1'b1; st_ok = 1'b1; vl_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (align_err !== 1'b1) al_ok = 1'b0;
            if (stall !== 1'b0) st_ok = 1'b0;
            if (bus_req_valid !== 1'b0) vl_ok = 1'b0;
            tick;
        end
        mem_read = 1'b0; addr = 32'h0;
        @(negedge clk);
        chk("t3_align_err", {31'd0, al_ok}, 32'd1);
        chk("t3_no_stall", {31'd0, st_ok}, 32'd1);
        chk("t3_no_bus_req", {31'd0, vl_ok}, 32'd1);
        chk("t3_read_data_held", read_data, model_rd);
        chk("t3_align_err_clear", {31'd0, align_err}, 32'd0);
        tick;

        // T4 timeout: accepted, no response ever
        do_access("t4", 1'b0, 32'h300, 32'h0, 0, 1'b0, 1'b0, 32'h77777777, sc, vc, st);
        chk("t4_req_wait_cycles", sc - 1, 32'd64);
        bus_rsp_valid = 1'b1; bus_rdata = 32'h12121212; bus_err = 1'b1;
        @(negedge clk);
        chk("t4_stray_no_stall", {31'd0, stall}, 32'd0);
        tick;
        bus_rsp_valid = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("t4_stray_read_data", read_data, 32'h0);
        chk("t4_stray_mem_err", {31'd0, mem_err}, 32'd0);
        tick;

        // T5 bus error on a load
        do_access("t5", 1'b0, 32'h400, 32'h0, 1, 1'b1, 1'b1, 32'hFFFF0000, sc, vc, st);
        @(negedge clk);
        chk("t5_mem_err_cleared", {31'd0, mem_err}, 32'd0);
        tick;

        // Good load so read_data is non-zero ahead of the reset test
        do_access("t5b", 1'b0, 32'h500, 32'h0, 0, 1'b1, 1'b0, 32'hCAFEF00D, sc, vc, st);

        // T6 reset while waiting for the response
        mem_read = 1'b1; addr = 32'h600; bus_req_ready = 1'b1;
        tick;
        mem_read = 1'b0; addr = 32'h0;
        tick;
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("t6_in_wait_stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("t6_rst_stall", {31'd0, stall}, 32'd0);
        chk("t6_rst_read_data", read_data, 32'h0);
        model_rd = 32'h0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick;
        do_access("t6_fresh", 1'b0, 32'h700, 32'h0, 0, 1'b1, 1'b0, 32'h0BADF00D, sc, vc, st);
        chk("t6_fresh_stall_cycles", sc, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
